// File: rtl/pp_pipeline_accel_ap_ctrl_caller.sv
// pp_pipeline_accel_ap_ctrl_caller: ap_ctrl_hs initiator that runs a child block cmd_count times and reports a summary
module pp_pipeline_accel_ap_ctrl_caller #(
  parameter int RET_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             child_ap_start,
  input  logic             child_ap_ready,
  input  logic             child_ap_done,
  input  logic             child_ap_idle,
  output logic             child_ap_continue,
  input  logic [RET_W-1:0] child_return,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RET_W-1:0] rsp_last_ret,
  output logic [RET_W-1:0] rsp_ret_or,
  output logic [CNT_W-1:0] rsp_calls,
  output logic             rsp_err,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d, issued_q, issued_d, completed_q, completed_d, rsp_calls_q, rsp_calls_d;
  logic [RET_W-1:0] last_q, last_d, or_q, or_d, rsp_last_q, rsp_last_d, rsp_or_q, rsp_or_d;
  logic err_q, err_d, rsp_err_q, rsp_err_d, fire, idle_unused;
  logic [CNT_W:0] avail;
  assign idle_unused = child_ap_idle;
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign rsp_valid = state_q == RESP;
  assign child_ap_start = (state_q == RUN) && (issued_q != target_q);
  assign child_ap_continue = ap_rst_n;
  assign fire = child_ap_start & child_ap_ready;
  assign avail = {1'b0, issued_q} + (CNT_W+1)'(fire);
  assign rsp_last_ret = rsp_last_q;
  assign rsp_ret_or = rsp_or_q;
  assign rsp_calls = rsp_calls_q;
  assign rsp_err = rsp_err_q;
  // next-state: accept commands, count issues/completions, snapshot the summary on the final completion
  always_comb begin
    state_d = state_q;
    target_d = target_q;
    issued_d = issued_q;
    completed_d = completed_q;
    last_d = last_q;
    or_d = or_q;
    err_d = err_q;
    rsp_calls_d = rsp_calls_q;
    rsp_last_d = rsp_last_q;
    rsp_or_d = rsp_or_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        target_d = cmd_count;
        issued_d = '0;
        completed_d = '0;
        last_d = '0;
        or_d = '0;
        err_d = 1'b0;
        if (cmd_count == '0) begin
          state_d = RESP;
          rsp_calls_d = '0;
          rsp_last_d = '0;
          rsp_or_d = '0;
          rsp_err_d = 1'b0;
        end else state_d = RUN;
      end
      RUN: begin
        issued_d = issued_q + CNT_W'(fire);
        if (child_ap_done) begin
          if ({1'b0, completed_q} < avail) begin
            completed_d = completed_q + CNT_W'(1);
            last_d = child_return;
            or_d = or_q | child_return;
          end else err_d = 1'b1;
        end
        if (completed_d == target_q) begin
          state_d = RESP;
          rsp_calls_d = completed_d;
          rsp_last_d = last_d;
          rsp_or_d = or_d;
          rsp_err_d = err_d;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state and counter registers with synchronous active-low clear
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      target_q <= '0;
      issued_q <= '0;
      completed_q <= '0;
      last_q <= '0;
      or_q <= '0;
      err_q <= 1'b0;
      rsp_calls_q <= '0;
      rsp_last_q <= '0;
      rsp_or_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      target_q <= target_d;
      issued_q <= issued_d;
      completed_q <= completed_d;
      last_q <= last_d;
      or_q <= or_d;
      err_q <= err_d;
      rsp_calls_q <= rsp_calls_d;
      rsp_last_q <= rsp_last_d;
      rsp_or_q <= rsp_or_d;
      rsp_err_q <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_pp_pipeline_accel_ap_ctrl_caller.sv
// tb_pp_pipeline_accel_ap_ctrl_caller: directed vectors and corner sequences for the ap_ctrl_hs caller
module tb_pp_pipeline_accel_ap_ctrl_caller;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b0, child_ap_idle = 1'b1;
  logic [15:0] cmd_count = '0;
  logic cmd_ready, child_ap_start, child_ap_ready, child_ap_done, child_ap_continue, rsp_valid, rsp_err, busy;
  logic [4:0] child_return, rsp_last_ret, rsp_ret_or;
  logic [15:0] rsp_calls;
  int mode = 0, ph = 0, cnt = 0, idx = 0, checks = 0, errors = 0;
  logic m_rdy = 1'b0, m_done = 1'b0, h_rdy = 1'b0, h_done = 1'b0;
  logic [4:0] m_ret = '0, h_ret = '0, c_ret = '0;
  typedef struct {
    logic [15:0] n;
    logic [4:0] ret;
    int lat;
    logic [15:0] calls;
    logic [4:0] last;
    logic [4:0] orv;
  } vec_t;
  vec_t vecs[5];

  pp_pipeline_accel_ap_ctrl_caller #(.RET_W(5), .CNT_W(16)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .child_ap_start(child_ap_start), .child_ap_ready(child_ap_ready),
    .child_ap_done(child_ap_done), .child_ap_idle(child_ap_idle), .child_ap_continue(child_ap_continue),
    .child_return(child_return), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_last_ret(rsp_last_ret), .rsp_ret_or(rsp_ret_or), .rsp_calls(rsp_calls),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  assign child_ap_ready = (mode == 0) ? child_ap_start : (mode == 1) ? m_rdy : h_rdy;
  assign child_ap_done = (mode == 0) ? child_ap_start : (mode == 1) ? m_done : h_done;
  assign child_return = (mode == 0) ? c_ret : (mode == 1) ? m_ret : h_ret;

  // multi-cycle child: ready 2 cycles after start is seen, done 4 cycles after ready, returns 1,2,4,...
  always @(posedge ap_clk) begin
    #2;
    m_rdy = 1'b0;
    m_done = 1'b0;
    if (mode == 1) begin
      if (ph == 0) begin
        if (child_ap_start) begin ph = 1; cnt = 0; end
      end else if (ph == 1) begin
        cnt = cnt + 1;
        if (cnt == 2) begin m_rdy = 1'b1; ph = 2; cnt = 0; end
      end else begin
        cnt = cnt + 1;
        if (cnt == 4) begin m_done = 1'b1; m_ret = 5'(1 << idx); idx = idx + 1; ph = 0; end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input logic [15:0] n, output int lat, output int starts, output int drops);
    logic ps, pr;
    @(negedge ap_clk);
    cmd_valid = 1'b1;
    cmd_count = n;
    @(posedge ap_clk);
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    lat = 0; starts = 0; drops = 0; ps = 1'b0; pr = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (ps && !pr && !child_ap_start) drops++;
      if (rsp_valid) begin lat = k; break; end
      if (child_ap_start) starts++;
      ps = child_ap_start;
      pr = child_ap_ready;
      @(negedge ap_clk);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 0);
  endtask

  initial begin
    int lat, st, dr;
    vecs[0] = '{16'd3, 5'd16, 4, 16'd3, 5'd16, 5'd16};
    vecs[1] = '{16'd0, 5'd16, 1, 16'd0, 5'd0, 5'd0};
    vecs[2] = '{16'd1, 5'd31, 2, 16'd1, 5'd31, 5'd31};
    vecs[3] = '{16'd5, 5'd10, 6, 16'd5, 5'd10, 5'd10};
    vecs[4] = '{16'd2, 5'd0, 3, 16'd2, 5'd0, 5'd0};
    repeat (2) @(negedge ap_clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_start", 32'(child_ap_start), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_continue", 32'(child_ap_continue), 0);
    chk("rst_calls", 32'(rsp_calls), 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("continue_on", 32'(child_ap_continue), 1);
    for (int i = 0; i < 5; i++) begin
      c_ret = vecs[i].ret;
      do_cmd(vecs[i].n, lat, st, dr);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_starts", i), 32'(st), 32'(vecs[i].n));
      chk($sformatf("v%0d_calls", i), 32'(rsp_calls), 32'(vecs[i].calls));
      chk($sformatf("v%0d_last", i), 32'(rsp_last_ret), 32'(vecs[i].last));
      chk($sformatf("v%0d_or", i), 32'(rsp_ret_or), 32'(vecs[i].orv));
      chk($sformatf("v%0d_err", i), 32'(rsp_err), 0);
      handshake();
    end
    mode = 1;
    do_cmd(16'd3, lat, st, dr);
    chk("mc_latency", 32'(lat), 22);
    chk("mc_start_drops", 32'(dr), 0);
    chk("mc_calls", 32'(rsp_calls), 3);
    chk("mc_last", 32'(rsp_last_ret), 4);
    chk("mc_or", 32'(rsp_ret_or), 7);
    chk("mc_err", 32'(rsp_err), 0);
    mode = 0;
    c_ret = 5'd3;
    cmd_valid = 1'b1;
    cmd_count = 16'd1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_cmd_ready", 32'(cmd_ready), 0);
      chk("stall_calls", 32'(rsp_calls), 3);
      chk("stall_last", 32'(rsp_last_ret), 4);
      chk("stall_or", 32'(rsp_ret_or), 7);
      @(negedge ap_clk);
    end
    rsp_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    rsp_ready = 1'b0;
    chk("post_hs_cmd_ready", 32'(cmd_ready), 1);
    chk("post_hs_busy", 32'(busy), 0);
    chk("post_hs_valid", 32'(rsp_valid), 0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    chk("second_cmd_busy", 32'(busy), 1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid) begin lat = k; break; end
      @(negedge ap_clk);
    end
    chk("second_cmd_latency", 32'(lat), 2);
    chk("second_cmd_calls", 32'(rsp_calls), 1);
    chk("second_cmd_last", 32'(rsp_last_ret), 3);
    handshake();
    mode = 2;
    @(negedge ap_clk);
    cmd_valid = 1'b1;
    cmd_count = 16'd2;
    @(posedge ap_clk);
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    h_done = 1'b1;
    h_ret = 5'd31;
    @(negedge ap_clk);
    chk("spur_start_held", 32'(child_ap_start), 1);
    h_rdy = 1'b1;
    h_done = 1'b1;
    h_ret = 5'd2;
    @(negedge ap_clk);
    h_ret = 5'd1;
    @(negedge ap_clk);
    h_rdy = 1'b0;
    h_done = 1'b0;
    chk("spur_valid", 32'(rsp_valid), 1);
    chk("spur_calls", 32'(rsp_calls), 2);
    chk("spur_err", 32'(rsp_err), 1);
    chk("spur_last", 32'(rsp_last_ret), 1);
    chk("spur_or", 32'(rsp_ret_or), 3);
    handshake();
    mode = 0;
    c_ret = 5'd7;
    cmd_valid = 1'b1;
    cmd_count = 16'd5;
    @(posedge ap_clk);
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    chk("mid_rst_start", 32'(child_ap_start), 0);
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_continue", 32'(child_ap_continue), 0);
    chk("mid_rst_calls", 32'(rsp_calls), 0);
    ap_rst_n = 1'b1;
    mode = 2;
    h_done = 1'b1;
    h_ret = 5'd31;
    @(negedge ap_clk);
    h_done = 1'b0;
    chk("stale_done_idle", 32'(busy), 0);
    mode = 0;
    c_ret = 5'd9;
    do_cmd(16'd2, lat, st, dr);
    chk("fresh_latency", 32'(lat), 3);
    chk("fresh_calls", 32'(rsp_calls), 2);
    chk("fresh_last", 32'(rsp_last_ret), 9);
    chk("fresh_or", 32'(rsp_ret_or), 9);
    chk("fresh_err", 32'(rsp_err), 0);
    handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pp_pipeline_accel_ap_ctrl_caller.md
Name: pp_pipeline_accel_ap_ctrl_caller

Overview:
- Initiator side of the ap_ctrl_hs block-level handshake. It drives ap_start and ap_continue into a child HLS block, such as the constant-return width/config helper blocks, and consumes its ap_ready, ap_done and return_r.
- On each accepted command it invokes the child cmd_count times and collects the return values. It then emits one summary response to the pipeline control logic.

Parameters:
- RET_W, 5, width of child return_r.
- CNT_W, 16, width of invocation counters.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept; high only in IDLE.
- cmd_count  in  CNT_W  number of child invocations requested; sampled on cmd_valid&cmd_ready.
- child_ap_start  out  1  ap_start to child.
- child_ap_ready  in  1  child accepted start.
- child_ap_done  in  1  child completed one invocation.
- child_ap_idle  in  1  child idle; informational only, not used for control.
- child_ap_continue  out  1  ap_continue to child.
- child_return  in  RET_W  child return_r; valid when child_ap_done=1.
- rsp_valid  out  1  summary valid.
- rsp_ready  in  1  summary accept.
- rsp_last_ret  out  RET_W  return value of the final invocation.
- rsp_ret_or  out  RET_W  bitwise OR of all return values.
- rsp_calls  out  CNT_W  completed invocation count.
- rsp_err  out  1  protocol error seen during the command.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, RUN, RESP.
- Reset (ap_rst_n=0 at a clock edge):
  - State goes to IDLE.
  - Counters issued, completed and accumulators cleared.
  - Outputs: cmd_ready=1 after reset; child_ap_start=0, rsp_valid=0, rsp_* =0, busy=0.
  - child_ap_continue=0 while ap_rst_n=0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch target=cmd_count and clear issued, completed, last, or, err.
  - If cmd_count==0, go to RESP (rsp_calls=0, rets=0). Otherwise go to RUN.
- RUN:
  - child_ap_start = (issued != target), combinational from registered state.
  - Start is held high until child_ap_ready is sampled high; it is never dropped mid-handshake.
  - child_ap_start & child_ap_ready: issued <= issued+1.
- Done handling (any state out of reset):
  - child_ap_continue=1 in IDLE, RUN and RESP, so completions are consumed in the cycle they appear and a stale child done_reg is drained.
- Completions in RUN (child_ap_done=1):
  - If completed < issued, or ready occurs in the same cycle (completed < issued+ready):
    - completed <= completed+1
    - last <= child_return
    - or <= or | child_return
  - Otherwise set err and ignore the value.
  - ready and done in the same cycle (single-cycle child) is legal and counts as issue plus completion.
- RUN -> RESP: in the cycle completed transitions to target. rsp_* registers are loaded from the updated values.
- RESP:
  - rsp_valid=1; outputs stable until rsp_ready.
  - rsp_valid & rsp_ready: go to IDLE, rsp_valid=0 next cycle.
  - rsp_* hold their values until the next command completes.
- Done outside RUN: dropped; no counter or err update.
- Latency:
  - cmd accepted at edge T: child_ap_start is high from cycle T+1.
  - With a single-cycle child: start high for target consecutive cycles, rsp_valid at cycle T+target+1.
  - count==0: rsp_valid at T+1.
- Widths:
  - Counters are CNT_W bits; target ≤ 2^CNT_W−1, so no wrap.
  - Returns are taken unsigned and unmodified.
- Reset mid-RUN: start drops after the reset edge and no response is produced. A child done arriving after reset is drained by continue and discarded.

Test Plan:
- Single-cycle child returning constant 16 (ready=done=1 whenever start=1), cmd_count=3 accepted at T. Required: start high T+1..T+3, rsp_valid at T+4, rsp_last_ret=16, rsp_ret_or=16, rsp_calls=3, rsp_err=0.
- cmd_count=0. Required: no child_ap_start, rsp_valid at T+1, rsp_calls=0, rsp_ret_or=0.
- Multi-cycle child (ready 2 cycles after start, done 4 cycles after ready) returning 1, 2, 4 over cmd_count=3. Required: start held through each ready, one invocation at a time, rsp_ret_or=7, rsp_last_ret=4, rsp_calls=3.
- rsp_ready low for 5 cycles in RESP. Required: rsp_valid and rsp_* stable, cmd_ready=0, and a second cmd_valid is not accepted until the cycle after the handshake.
- Spurious child_ap_done pulse in RUN with completed==issued and no ready. Required: rsp_err=1 and rsp_calls unaffected (still equals cmd_count).
- ap_rst_n=0 for 1 cycle mid-RUN of cmd_count=5 after 2 completions. Required: next cycle IDLE, child_ap_start=0, rsp_valid=0, cmd_ready=1; a fresh command of count 2 then completes normally with rsp_calls=2.
